// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write path: buffer ids,
// error flag positions, sequencer states and simulation log levels.
package fb_pkg;

    typedef logic [1:0] buffer_id_t;

    localparam int         NUM_BUFFERS       = 3;
    localparam buffer_id_t BUFFER_ID_INVALID = 2'd3;

    localparam int ERR_WIDTH       = 4;
    localparam int ERR_OVERRUN     = 0;
    localparam int ERR_SHORT_FRAME = 1;
    localparam int ERR_EXTRA_LINE  = 2;
    localparam int ERR_BAD_ID      = 3;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_REQ,
        SEQ_REL,
        SEQ_WAIT_LINE,
        SEQ_ISSUE,
        SEQ_FIN
    } seq_state_t;

    typedef enum int {
        SVL_VERBOSE_NONE,
        SVL_VERBOSE_ERROR,
        SVL_VERBOSE_WARN,
        SVL_VERBOSE_INFO,
        SVL_VERBOSE_DEBUG
    } log_level_t;

endpackage

// File: rtl/frame_addr_gen.sv
// Address accumulator for frame writes: selects the buffer base, advances one
// burst per accepted command and counts bursts within a line and lines in a frame.
module frame_addr_gen
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 21,
    parameter int WORDS_PER_LINE = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int BURST_WORDS    = 32,
    parameter int BASE_ADDR      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  buffer_id_t            buffer_id,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_burst,
    output logic                  last_line
);

    localparam int BURSTS_PER_LINE = WORDS_PER_LINE / BURST_WORDS;
    localparam int BURST_CNT_W     = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
    localparam int LINE_CNT_W      = $clog2(FRAME_HEIGHT + 1);

    // Buffer bases are built by repeated constant adds, so no multiplier exists.
    localparam logic [ADDR_WIDTH-1:0] FRAME_WORDS_A = ADDR_WIDTH'(WORDS_PER_LINE * FRAME_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] BASE0         = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE1         = BASE0 + FRAME_WORDS_A;
    localparam logic [ADDR_WIDTH-1:0] BASE2         = BASE1 + FRAME_WORDS_A;
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP    = ADDR_WIDTH'(BURST_WORDS);

    logic [ADDR_WIDTH-1:0]  acc_q;
    logic [ADDR_WIDTH-1:0]  base_sel;
    logic [BURST_CNT_W-1:0] burst_cnt_q;
    logic [LINE_CNT_W-1:0]  line_cnt_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        base_sel = BASE0;
        case (buffer_id)
            2'd1:    base_sel = BASE1;
            2'd2:    base_sel = BASE2;
            default: base_sel = BASE0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q       <= '0;
            burst_cnt_q <= '0;
            line_cnt_q  <= '0;
        end else if (load) begin
            acc_q       <= base_sel;
            burst_cnt_q <= '0;
            line_cnt_q  <= '0;
        end else if (step) begin
            acc_q <= acc_q + BURST_STEP;
            if (last_burst) begin
                burst_cnt_q <= '0;
                line_cnt_q  <= line_cnt_q + LINE_CNT_W'(1);
            end else begin
                burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
            end
        end
    end

    assign addr       = acc_q;
    assign last_burst = (burst_cnt_q == BURST_CNT_W'(BURSTS_PER_LINE - 1));
    assign last_line  = (line_cnt_q == LINE_CNT_W'(FRAME_HEIGHT));

endmodule

// File: rtl/frame_write_sequencer.sv
// Write-side client of the triple-buffer controller: acquires a buffer per frame,
// turns each ready line into SDRAM burst-write commands and finalizes the buffer.
module frame_write_sequencer
    import fb_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 21,
    parameter int         WORDS_PER_LINE = 640,
    parameter int         FRAME_HEIGHT   = 480,
    parameter int         BURST_WORDS    = 32,
    parameter int         BASE_ADDR      = 0,
    parameter log_level_t LOG_LEVEL      = SVL_VERBOSE_INFO
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  line_ready,
    input  logic                  frame_end,
    output logic                  line_release,
    output logic                  write_rq_rdy,
    output logic                  finalize_wr,
    input  logic                  buffer_id_valid,
    input  buffer_id_t            buffer_id,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    output logic                  frame_done,
    output logic [ERR_WIDTH-1:0]  err_flags
);

    localparam longint FRAME_WORDS_L = longint'(WORDS_PER_LINE) * longint'(FRAME_HEIGHT);
    localparam bit PARAMS_OK =
        (BURST_WORDS > 0) && (BURST_WORDS <= 256) && (FRAME_HEIGHT > 0) &&
        (WORDS_PER_LINE >= BURST_WORDS) &&
        ((WORDS_PER_LINE % ((BURST_WORDS > 0) ? BURST_WORDS : 1)) == 0) &&
        (longint'(BASE_ADDR) + longint'(NUM_BUFFERS) * FRAME_WORDS_L <= (longint'(1) << ADDR_WIDTH));

    if (!PARAMS_OK) begin : g_param_check
        $fatal(1, "frame_write_sequencer: illegal parameter set");
    end

    seq_state_t             state_q, state_d;
    buffer_id_t             id_q;
    logic                   end_pend_q;
    logic [ERR_WIDTH-1:0]   err_q;
    logic                   line_release_q;
    logic                   frame_done_q;
    logic                   cmd_accept;
    logic                   addr_load;
    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic                   last_burst;
    logic                   last_line;

    frame_addr_gen #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .FRAME_HEIGHT   (FRAME_HEIGHT),
        .BURST_WORDS    (BURST_WORDS),
        .BASE_ADDR      (BASE_ADDR)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (addr_load),
        .step       (cmd_accept),
        .buffer_id  (id_q),
        .addr       (acc_addr),
        .last_burst (last_burst),
        .last_line  (last_line)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= SEQ_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:      if (frame_start) state_d = SEQ_REQ;
            SEQ_REQ:       if (buffer_id_valid) state_d = SEQ_REL;
            SEQ_REL:
                if (!buffer_id_valid)
                    state_d = (id_q == BUFFER_ID_INVALID) ? SEQ_FIN : SEQ_WAIT_LINE;
            // A frame end, fresh or deferred from ISSUE, beats any line_ready.
            SEQ_WAIT_LINE:
                if (frame_end || end_pend_q)      state_d = SEQ_FIN;
                else if (line_ready && !last_line) state_d = SEQ_ISSUE;
            SEQ_ISSUE:     if (cmd_accept && last_burst) state_d = SEQ_WAIT_LINE;
            SEQ_FIN:       state_d = SEQ_IDLE;
            default:       state_d = SEQ_IDLE;
        endcase
    end

    always_comb begin
        write_rq_rdy = (state_q == SEQ_REQ);
        cmd_valid    = (state_q == SEQ_ISSUE);
        finalize_wr  = (state_q == SEQ_FIN);
        cmd_addr     = cmd_valid ? acc_addr : '0;
        cmd_len      = cmd_valid ? 8'(BURST_WORDS - 1) : '0;
        cmd_accept   = cmd_valid && cmd_ready;
        addr_load    = (state_q == SEQ_REL) && !buffer_id_valid && (id_q != BUFFER_ID_INVALID);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_q           <= '0;
            end_pend_q     <= 1'b0;
            err_q          <= '0;
            line_release_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            line_release_q <= cmd_accept && last_burst;
            frame_done_q   <= (state_q == SEQ_FIN);

            if (state_q == SEQ_REQ && buffer_id_valid) begin
                id_q <= buffer_id;
                if (buffer_id == BUFFER_ID_INVALID) err_q[ERR_BAD_ID] <= 1'b1;
            end

            // The line in flight always completes; late events are flagged or deferred.
            if (state_q == SEQ_ISSUE) begin
                if (frame_end)  end_pend_q         <= 1'b1;
                if (line_ready) err_q[ERR_OVERRUN] <= 1'b1;
            end

            if (state_q == SEQ_WAIT_LINE) begin
                if (frame_end || end_pend_q) begin
                    if (!last_line) err_q[ERR_SHORT_FRAME] <= 1'b1;
                end else if (line_ready && last_line) begin
                    err_q[ERR_EXTRA_LINE] <= 1'b1;
                end
            end

            if (state_q == SEQ_FIN) end_pend_q <= 1'b0;
        end
    end

    assign line_release = line_release_q;
    assign frame_done   = frame_done_q;
    assign err_flags    = err_q;

    // The line counter can never sit at FRAME_HEIGHT while a command is pending.
    always @(posedge clk) begin
        if (LOG_LEVEL >= SVL_VERBOSE_WARN && reset_n && cmd_valid) begin
            assert (!last_line);
        end
    end

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed bench for frame_write_sequencer with a behavioural buffer controller
// and a scoreboard of expected burst addresses.
module tb_frame_write_sequencer;
    import fb_pkg::*;

    localparam int AW  = 21;
    localparam int WPL = 8;
    localparam int BW  = 4;
    localparam int FH  = 3;
    localparam int FW  = WPL * FH;

    localparam int EV_ACCEPT  = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_FINAL   = 2;
    localparam int EV_DONE    = 3;
    localparam int EV_GRANT   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_ready = 1'b0;
    logic          frame_end = 1'b0;
    logic          buffer_id_valid = 1'b0;
    buffer_id_t    buffer_id = '0;
    logic          cmd_ready = 1'b0;
    logic          line_release, write_rq_rdy, finalize_wr, cmd_valid, frame_done;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [3:0]    err_flags;

    int errors = 0;
    int checks = 0;
    int n_accept = 0, n_release = 0, n_final = 0, n_done = 0, n_grant = 0;
    int exp_q[$];
    int exp_addr;
    logic stub_bad_id = 1'b0;
    int next_id = 1;
    int granted_id = 0;

    always #5 clk = ~clk;

    frame_write_sequencer #(
        .ADDR_WIDTH     (AW),
        .WORDS_PER_LINE (WPL),
        .FRAME_HEIGHT   (FH),
        .BURST_WORDS    (BW),
        .BASE_ADDR      (0),
        .LOG_LEVEL      (SVL_VERBOSE_INFO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_start     (frame_start),
        .line_ready      (line_ready),
        .frame_end       (frame_end),
        .line_release    (line_release),
        .write_rq_rdy    (write_rq_rdy),
        .finalize_wr     (finalize_wr),
        .buffer_id_valid (buffer_id_valid),
        .buffer_id       (buffer_id),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .frame_done      (frame_done),
        .err_flags       (err_flags)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor at the falling edge: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            n_accept++;
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", 32'(cmd_addr), 32'hFFFF_FFFF);
            end else begin
                exp_addr = exp_q.pop_front();
                check("cmd_addr", 32'(cmd_addr), exp_addr);
                check("cmd_len", 32'(cmd_len), BW - 1);
            end
        end
        if (line_release) n_release++;
        if (finalize_wr)  n_final++;
        if (frame_done)   n_done++;
    end

    // Controller model: the reader consumes every published frame, so grants rotate 1,2,0,...
    initial begin : controller
        forever begin
            @(posedge clk);
            #1;
            if (write_rq_rdy) begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                buffer_id       = stub_bad_id ? BUFFER_ID_INVALID : buffer_id_t'(next_id);
                granted_id      = int'(buffer_id);
                buffer_id_valid = 1'b1;
                @(posedge clk);
                #1;
                buffer_id_valid = 1'b0;
                if (!stub_bad_id) next_id = (next_id + 1) % NUM_BUFFERS;
                n_grant++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_event(input string tag, input int which, input int target);
        int cnt;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            case (which)
                EV_ACCEPT:  cnt = n_accept;
                EV_RELEASE: cnt = n_release;
                EV_FINAL:   cnt = n_final;
                EV_DONE:    cnt = n_done;
                default:    cnt = n_grant;
            endcase
            if (cnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic start_frame(output int base);
        int g;
        g = n_grant;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("rq_asserted", 32'(write_rq_rdy), 1);
        wait_event("grant", EV_GRANT, g + 1);
        tick(2);
        check("rq_dropped", 32'(write_rq_rdy), 0);
        base = granted_id * FW;
    endtask

    task automatic do_line(input int base, input int line);
        int r;
        r = n_release;
        for (int b = 0; b < WPL / BW; b++) exp_q.push_back(base + line * WPL + b * BW);
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        wait_event("line_release", EV_RELEASE, r + 1);
        tick();
    endtask

    task automatic end_frame(input bit with_start);
        int d;
        d = n_done;
        frame_end   = 1'b1;
        frame_start = with_start;
        tick();
        frame_end   = 1'b0;
        frame_start = 1'b0;
        wait_event("frame_done", EV_DONE, d + 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin : stimulus
        int base;
        int a0, r0, f0, d0;

        // Reset state
        cmd_ready = 1'b1;
        reset_n   = 1'b0;
        tick(3);
        check("reset_ctrl", 32'({line_release, write_rq_rdy, finalize_wr, cmd_valid, frame_done, err_flags}), 0);
        check("reset_cmd", 32'({cmd_addr, cmd_len}), 0);
        reset_n = 1'b1;
        tick();

        // First frame, id 1: addresses 24..44; frame_start together with frame_end is ignored
        start_frame(base);
        for (int l = 0; l < FH; l++) do_line(base, l);
        end_frame(1'b1);
        tick(3);
        check("first_accepts", n_accept, 6);
        check("first_releases", n_release, 3);
        check("first_finalize", n_final, 1);
        check("first_done", n_done, 1);
        check("first_err", 32'(err_flags), 0);
        check("first_no_restart", 32'(write_rq_rdy), 0);
        check("first_queue_empty", exp_q.size(), 0);

        // Backpressure on the second burst of a line
        a0 = n_accept;
        r0 = n_release;
        start_frame(base);
        exp_q.push_back(base);
        exp_q.push_back(base + BW);
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        wait_event("bp_first_accept", EV_ACCEPT, a0 + 1);
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(cmd_valid), 1);
            check("bp_addr_held", 32'(cmd_addr), base + BW);
            tick();
        end
        cmd_ready = 1'b1;
        wait_event("bp_release", EV_RELEASE, r0 + 1);
        tick();
        do_line(base, 1);
        do_line(base, 2);
        end_frame(1'b0);
        check("bp_accepts", n_accept - a0, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Short frame with frame_end arriving while a line is being issued
        do_reset();
        a0 = n_accept;
        f0 = n_final;
        d0 = n_done;
        start_frame(base);
        do_line(base, 0);
        exp_q.push_back(base + WPL);
        exp_q.push_back(base + WPL + BW);
        cmd_ready  = 1'b0;
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        frame_end  = 1'b1;
        tick();
        frame_end  = 1'b0;
        tick(2);
        check("short_line_pending", 32'(cmd_valid), 1);
        cmd_ready = 1'b1;
        wait_event("short_done", EV_DONE, d0 + 1);
        check("short_accepts", n_accept - a0, 4);
        check("short_finalize", n_final - f0, 1);
        check("short_err", 32'(err_flags), 32'b0010);
        check("short_queue_empty", exp_q.size(), 0);

        // Overrun during ISSUE, then an extra fourth line
        do_reset();
        r0 = n_release;
        start_frame(base);
        exp_q.push_back(base);
        exp_q.push_back(base + BW);
        cmd_ready  = 1'b0;
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        tick();
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        check("overrun_err", 32'(err_flags), 32'b0001);
        cmd_ready = 1'b1;
        wait_event("overrun_release", EV_RELEASE, r0 + 1);
        tick();
        do_line(base, 1);
        do_line(base, 2);
        a0 = n_accept;
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        tick(5);
        check("extra_no_cmd", n_accept - a0, 0);
        check("extra_idle_bus", 32'(cmd_valid), 0);
        check("extra_err", 32'(err_flags), 32'b0101);
        end_frame(1'b0);
        check("extra_err_final", 32'(err_flags), 32'b0101);
        check("extra_queue_empty", exp_q.size(), 0);

        // Reset while a command is pending, then a clean frame
        do_reset();
        start_frame(base);
        cmd_ready  = 1'b0;
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        check("mid_issue_valid", 32'(cmd_valid), 1);
        f0 = n_final;
        reset_n = 1'b0;
        tick();
        check("mid_reset_ctrl", 32'({line_release, write_rq_rdy, finalize_wr, cmd_valid, frame_done, err_flags}), 0);
        check("mid_reset_cmd", 32'({cmd_addr, cmd_len}), 0);
        tick();
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        tick(3);
        check("mid_no_finalize", n_final - f0, 0);
        a0 = n_accept;
        start_frame(base);
        for (int l = 0; l < FH; l++) do_line(base, l);
        end_frame(1'b0);
        check("fresh_accepts", n_accept - a0, 6);
        check("fresh_finalize", n_final - f0, 1);
        check("fresh_err", 32'(err_flags), 0);

        // Ten back-to-back frames
        a0 = n_accept;
        f0 = n_final;
        for (int f = 0; f < 10; f++) begin
            start_frame(base);
            for (int l = 0; l < FH; l++) do_line(base, l);
            end_frame(1'b0);
        end
        check("b2b_accepts", n_accept - a0, 60);
        check("b2b_finalize", n_final - f0, 10);
        check("b2b_err", 32'(err_flags), 0);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Controller stub hands out the invalid id 3
        do_reset();
        stub_bad_id = 1'b1;
        a0 = n_accept;
        f0 = n_final;
        d0 = n_done;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_event("bad_id_done", EV_DONE, d0 + 1);
        stub_bad_id = 1'b0;
        tick(2);
        check("bad_id_err", 32'(err_flags), 32'b1000);
        check("bad_id_no_cmd", n_accept - a0, 0);
        check("bad_id_finalize", n_final - f0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_write_sequencer.md
Name: frame_write_sequencer

Overview:
Write-side client of the triple-buffer controller. On each camera frame it acquires a write buffer id through the controller's request/valid handshake, then turns every "line ready" event from the line buffer into a run of SDRAM burst-write commands at the correct frame address. At frame end it pulses finalize_wr so the controller can publish the buffer to the reader.

Parameters:
ADDR_WIDTH, 21, SDRAM word-address width.
WORDS_PER_LINE, 640, memory words per video line.
FRAME_HEIGHT, 480, lines per frame.
BURST_WORDS, 32, words per write command; WORDS_PER_LINE must be an integer multiple of it.
BASE_ADDR, 0, word address of buffer 0.
LOG_LEVEL, SVL_VERBOSE_INFO, simulation logging verbosity.

Ports:
clk  in  1  system clock (fb_clk domain).
reset_n  in  1  synchronous, active-low reset.
frame_start  in  1  one-cycle pulse at camera VSYNC end.
line_ready  in  1  one-cycle pulse: a full line is held in the line buffer.
frame_end  in  1  one-cycle pulse at camera frame end.
line_release  out  1  one-cycle pulse: line buffer may be overwritten.
write_rq_rdy  out  1  buffer request to the controller.
finalize_wr  out  1  one-cycle buffer-finalize pulse.
buffer_id_valid  in  1  controller id-valid.
buffer_id  in  2  controller buffer index.
cmd_valid  out  1  burst command valid.
cmd_ready  in  1  memory side accepts command.
cmd_addr  out  ADDR_WIDTH  burst start word address.
cmd_len  out  8  burst length (BURST_WORDS-1).
frame_done  out  1  one-cycle pulse after finalize.
err_flags  out  4  sticky: [0] line overrun, [1] short frame, [2] extra line, [3] bad buffer id.

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE. All outputs 0. Line and burst counters 0. err_flags cleared. An in-flight request or command is abandoned; finalize is not issued.
- Derived constants: BURSTS_PER_LINE = WORDS_PER_LINE/BURST_WORDS; FRAME_WORDS = WORDS_PER_LINE*FRAME_HEIGHT.
- IDLE: frame_start moves to REQ. All other inputs are ignored.
- REQ: write_rq_rdy=1. It is held until buffer_id_valid=1. On that cycle buffer_id is latched, write_rq_rdy drops on the next edge, and the state moves to REL.
- REL: waits for buffer_id_valid=0, then moves to WAIT_LINE.
- Bad buffer id: if the latched id is 3, err_flags[3] is set and the state goes straight to FIN, with no commands issued.
- Frame base address: BASE_ADDR + id*FRAME_WORDS, computed by a two-step add from constants. No runtime multiplier. The base loads into the address accumulator on leaving REL.
- WAIT_LINE:
  - line_ready moves to ISSUE.
  - frame_end moves to FIN. If lines written < FRAME_HEIGHT, err_flags[1] is set.
  - line_ready when lines written == FRAME_HEIGHT sets err_flags[2] and is dropped.
- ISSUE: cmd_valid=1 with cmd_addr=accumulator and cmd_len=BURST_WORDS-1.
  - On cmd_valid&cmd_ready the accumulator advances by BURST_WORDS and the burst counter increments.
  - After the last burst of the line is accepted: line_release pulses, the line counter increments, and the state returns to WAIT_LINE (1-cycle turnaround).
  - cmd_addr and cmd_len stay stable while cmd_valid=1 and cmd_ready=0.
- Events arriving during ISSUE:
  - line_ready sets err_flags[0] and is dropped.
  - frame_end is latched and honoured on return to WAIT_LINE. The current line completes first.
- FIN: finalize_wr=1 for exactly one cycle. The next cycle pulses frame_done and returns to IDLE.
- frame_start outside IDLE: ignored (no restart). Simultaneous frame_start and frame_end in WAIT_LINE: frame_end wins.
- Address never wraps. Parameter legality, including 3*FRAME_WORDS+BASE_ADDR <= 2^ADDR_WIDTH, is checked by a simulation-only assertion.

Decomposition:
- Shared package fb_pkg:
  - buffer_id_t (logic [1:0]).
  - NUM_BUFFERS=3 and BUFFER_ID_INVALID=2'd3.
  - err_flags bit indices.
  - Sequencer state enum (IDLE, REQ, REL, WAIT_LINE, ISSUE, FIN).
- One natural sub-module: frame_addr_gen. It holds the base select, the accumulator, and the burst/line counters, with load/step/last_burst/last_line outputs. Everything else stays in the top FSM.

Test Plan:
All scenarios use WORDS_PER_LINE=8, BURST_WORDS=4, FRAME_HEIGHT=3 (FRAME_WORDS=24), BASE_ADDR=0, with a real BufferController instance on the controller side unless a scenario states otherwise.
- First frame: frame_start, 3 line_ready, cmd_ready=1 -> id 1 granted; cmd_addr sequence 24,28,32,36,40,44; 3 line_release pulses; one finalize_wr; frame_done; err_flags=0.
- Ten back-to-back frames, with the bench reader finalizing between frames -> latched ids cycle 1,2,0,1,…; each frame's first cmd_addr is id*24; no hang within 500 us.
- Backpressure: cmd_ready low for 5 cycles on the 2nd burst -> cmd_addr holds 28 and cmd_valid stays high; no duplicate or missing command.
- Short frame: 2 line_ready then frame_end -> 4 commands; finalize issued; err_flags[1]=1.
- Overrun and extra line:
  - line_ready during ISSUE -> err_flags[0]=1; the current line completes normally.
  - A 4th line_ready before frame_end -> err_flags[2]=1 and no command is issued for it.
- Reset mid-ISSUE and bad id:
  - reset_n low during ISSUE -> all outputs 0 next cycle; no finalize_wr; a fresh frame then succeeds.
  - With a bench-driven controller stub returning id 3 -> err_flags[3]=1; zero commands; one finalize_wr.
